// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared FSM state type and address field-width helpers for cache_sa_wb
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    RESP = 2'd3
  } state_t;

  // Byte-offset bits within one word/line
  function automatic int off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Index bits for a power-of-2 count (sets or ways)
  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

  // Tag bits: whatever is left above index and offset
  function automatic int tag_w(input int addr_w, input int data_w, input int num_sets);
    return addr_w - off_w(data_w) - idx_w(num_sets);
  endfunction

endpackage

// File: rtl/cache_lru.sv
// rtl/cache_lru.sv - per-set true-LRU age vectors with victim selection and touch update
module cache_lru
  import cache_pkg::*;
#(
  parameter int NUM_SETS = 4,
  parameter int WAYS     = 2
)(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [idx_w(NUM_SETS)-1:0]   i_set,
  input  logic [WAYS-1:0]              i_valid,
  output logic [idx_w(WAYS)-1:0]       o_victim,
  input  logic                         i_touch,
  input  logic [idx_w(NUM_SETS)-1:0]   i_touch_set,
  input  logic [idx_w(WAYS)-1:0]       i_touch_way
);

  localparam int WAY_W = idx_w(WAYS);

  logic [WAY_W-1:0] r_age [NUM_SETS][WAYS];
  logic             w_found;

  // Victim: lowest-index invalid way, otherwise the oldest way (age WAYS-1)
  always_comb begin
    o_victim = '0;
    w_found  = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!w_found && !i_valid[w]) begin
        o_victim = WAY_W'(w);
        w_found  = 1'b1;
      end
    end
    if (!w_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (r_age[i_set][w] == WAY_W'(WAYS - 1)) o_victim = WAY_W'(w);
      end
    end
  end

  // Touch makes the way youngest; ways younger than it age by one, keeping a permutation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < WAYS; w++)
          r_age[s][w] <= WAY_W'(w);
    end else if (i_touch) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == i_touch_way)
          r_age[i_touch_set][w] <= '0;
        else if (r_age[i_touch_set][w] < r_age[i_touch_set][i_touch_way])
          r_age[i_touch_set][w] <= r_age[i_touch_set][w] + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_sa_wb.sv
// rtl/cache_sa_wb.sv - N-way set-associative write-back write-allocate cache, one word per line
module cache_sa_wb
  import cache_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int NUM_SETS = 4,
  parameter int WAYS     = 2,
  parameter int CNT_W    = 16
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int OFF_W = off_w(DATA_W);
  localparam int IDX_W = idx_w(NUM_SETS);
  localparam int TAG_W = tag_w(ADDR_W, DATA_W, NUM_SETS);
  localparam int WAY_W = idx_w(WAYS);

  state_t r_state, w_next;

  logic [WAYS-1:0]   r_valid [NUM_SETS];
  logic [WAYS-1:0]   r_dirty [NUM_SETS];
  logic [TAG_W-1:0]  r_tag   [NUM_SETS][WAYS];
  logic [DATA_W-1:0] r_data  [NUM_SETS][WAYS];

  logic              r_write;
  logic [IDX_W-1:0]  r_idx;
  logic [TAG_W-1:0]  r_rtag;
  logic [DATA_W-1:0] r_wdata;
  logic [WAY_W-1:0]  r_way;
  logic [TAG_W-1:0]  r_vtag;
  logic [DATA_W-1:0] r_vdata;
  logic              r_hit_pulse;
  logic [DATA_W-1:0] r_rdata;
  logic [CNT_W-1:0]  r_hit_cnt, r_miss_cnt;

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_accept, w_hit, w_vdirty;
  logic [WAY_W-1:0]  w_hit_way, w_victim;
  logic              w_inst, w_inst_dirty, w_touch;
  logic [IDX_W-1:0]  w_inst_set;
  logic [WAY_W-1:0]  w_inst_way, w_touch_way;
  logic [TAG_W-1:0]  w_inst_tag;
  logic [DATA_W-1:0] w_inst_data;
  logic              w_unused_addr;

  assign w_idx         = req_addr[OFF_W +: IDX_W];
  assign w_tag         = req_addr[ADDR_W-1 -: TAG_W];
  assign w_unused_addr = &{1'b0, req_addr[OFF_W-1:0]};
  assign w_accept      = req_valid && (r_state == IDLE);
  assign w_vdirty      = r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim];

  assign resp_valid = r_hit_pulse || (r_state == RESP);
  assign resp_hit   = r_hit_pulse;
  assign resp_rdata = r_rdata;
  assign hit_cnt    = r_hit_cnt;
  assign miss_cnt   = r_miss_cnt;

  cache_lru #(.NUM_SETS(NUM_SETS), .WAYS(WAYS)) u_lru (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_set       (w_idx),
    .i_valid     (r_valid[w_idx]),
    .o_victim    (w_victim),
    .i_touch     (w_touch),
    .i_touch_set (w_inst_set),
    .i_touch_way (w_touch_way)
  );

  // Tag lookup of the incoming request against every way of its set
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
  end

  // Line install: write hit, clean write miss, write after writeback, or fill return
  always_comb begin
    w_inst       = 1'b0;
    w_inst_set   = w_idx;
    w_inst_way   = w_victim;
    w_inst_tag   = w_tag;
    w_inst_data  = req_wdata;
    w_inst_dirty = 1'b1;
    case (r_state)
      IDLE: begin
        if (w_accept && req_write) begin
          if (w_hit) begin
            w_inst     = 1'b1;
            w_inst_way = w_hit_way;
          end else if (!w_vdirty) begin
            w_inst = 1'b1;
          end
        end
      end
      WB: begin
        if (mem_ack && r_write) begin
          w_inst      = 1'b1;
          w_inst_set  = r_idx;
          w_inst_way  = r_way;
          w_inst_tag  = r_rtag;
          w_inst_data = r_wdata;
        end
      end
      FILL: begin
        if (mem_ack) begin
          w_inst       = 1'b1;
          w_inst_set   = r_idx;
          w_inst_way   = r_way;
          w_inst_tag   = r_rtag;
          w_inst_data  = mem_rdata;
          w_inst_dirty = 1'b0;
        end
      end
      default: ;
    endcase
    w_touch     = w_inst || (w_accept && w_hit);
    w_touch_way = w_inst ? w_inst_way : w_hit_way;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // FSM next state and memory-port drive
  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (w_accept && !w_hit) begin
          if (w_vdirty)       w_next = WB;
          else if (req_write) w_next = RESP;
          else                w_next = FILL;
        end
      end
      WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {r_vtag, r_idx, {OFF_W{1'b0}}};
        mem_wdata = r_vdata;
        if (mem_ack) w_next = r_write ? RESP : FILL;
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = {r_rtag, r_idx, {OFF_W{1'b0}}};
        if (mem_ack) w_next = RESP;
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Line valid/dirty flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
      end
    end else if (w_inst) begin
      r_valid[w_inst_set][w_inst_way] <= 1'b1;
      r_dirty[w_inst_set][w_inst_way] <= w_inst_dirty;
    end
  end

  // Tag and data storage; contents are meaningless until the valid bit is set
  always_ff @(posedge clk) begin
    if (w_inst) begin
      r_tag[w_inst_set][w_inst_way]  <= w_inst_tag;
      r_data[w_inst_set][w_inst_way] <= w_inst_data;
    end
  end

  // Request capture, response data and saturating statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write     <= 1'b0;
      r_idx       <= '0;
      r_rtag      <= '0;
      r_wdata     <= '0;
      r_way       <= '0;
      r_vtag      <= '0;
      r_vdata     <= '0;
      r_hit_pulse <= 1'b0;
      r_rdata     <= '0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
    end else begin
      r_hit_pulse <= w_accept && w_hit;
      if (w_accept) begin
        r_write <= req_write;
        r_idx   <= w_idx;
        r_rtag  <= w_tag;
        r_wdata <= req_wdata;
        r_way   <= w_victim;
        r_vtag  <= r_tag[w_idx][w_victim];
        r_vdata <= r_data[w_idx][w_victim];
        if (w_hit) begin
          if (r_hit_cnt != {CNT_W{1'b1}}) r_hit_cnt <= r_hit_cnt + 1'b1;
        end else begin
          if (r_miss_cnt != {CNT_W{1'b1}}) r_miss_cnt <= r_miss_cnt + 1'b1;
        end
      end
      if (w_inst)                  r_rdata <= w_inst_data;
      else if (w_accept && w_hit)  r_rdata <= r_data[w_idx][w_hit_way];
    end
  end

endmodule

// File: tb/tb_cache_sa_wb.sv
// tb/tb_cache_sa_wb.sv - directed self-checking bench for cache_sa_wb
module tb_cache_sa_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_hit;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] hit_cnt, miss_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  int ack_dly = 1;
  int mcnt    = 0;
  int seq     = 0;
  int wb_cnt = 0, fill_cnt = 0, wb_seq = 0, fill_seq = 0;
  logic [31:0] last_wb_addr = 0, last_wb_data = 0, last_fill_addr = 0;

  always #5 clk = ~clk;

  cache_sa_wb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_hit   (resp_hit),
    .resp_rdata (resp_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h0) return 32'h1111_0000;
    return {16'hA5A5, a[15:0]};
  endfunction

  // Backing memory: acks once mem_req has been seen for more than ack_dly samples
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n || mem_ack) begin
        mem_ack = 1'b0;
        mcnt    = 0;
      end else if (mem_req) begin
        mcnt++;
        if (mcnt > ack_dly) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_we ? 32'h0 : mem_val(mem_addr);
          seq++;
          if (mem_we) begin
            wb_cnt++; last_wb_addr = mem_addr; last_wb_data = mem_wdata; wb_seq = seq;
          end else begin
            fill_cnt++; last_fill_addr = mem_addr; fill_seq = seq;
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic hit, output logic [31:0] rd, output int lat);
    int cyc;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = ~w; req_addr = 32'hFFFF_FFFC; req_wdata = 32'h0BAD_0BAD;
    cyc = 0;
    while (!resp_valid && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!resp_valid) check("resp_timeout", 64'd0, 64'd1);
    hit = resp_hit; rd = resp_rdata; lat = cyc + 1;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        hit;
    logic [31:0] data;
  } vec_t;

  initial begin
    logic        h;
    logic [31:0] rd;
    int          lat, fc, wc, nreq, nresp, mc, hc;
    logic        stable_ok, ready_bad, got_hit;
    logic [31:0] got_rd;
    vec_t        t2 [5];

    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
    do_reset();

    check("rst_req_ready",  req_ready,  1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_mem_req",    mem_req,    0);
    check("rst_mem_addr",   mem_addr,   0);
    check("rst_hit_cnt",    hit_cnt,    0);
    check("rst_miss_cnt",   miss_cnt,   0);

    // Test 1: cold read fills, repeat read hits in one cycle
    do_req(0, 32'h0, 0, h, rd, lat);
    check("t1_miss_hit",   h,  0);
    check("t1_miss_data",  rd, 32'h1111_0000);
    check("t1_fill_cnt",   fill_cnt, 1);
    check("t1_fill_addr",  last_fill_addr, 32'h0);
    fc = fill_cnt;
    do_req(0, 32'h0, 0, h, rd, lat);
    check("t1_hit",        h,   1);
    check("t1_hit_data",   rd,  32'h1111_0000);
    check("t1_hit_lat",    lat, 1);
    check("t1_no_mem",     fill_cnt, fc);

    // Test 2: two-way set 0 with LRU eviction
    t2[0] = '{32'h40, 1'b0, 32'hA5A5_0040};
    t2[1] = '{32'h40, 1'b1, 32'hA5A5_0040};
    t2[2] = '{32'h00, 1'b1, 32'h1111_0000};
    t2[3] = '{32'h80, 1'b0, 32'hA5A5_0080};
    t2[4] = '{32'h40, 1'b0, 32'hA5A5_0040};
    foreach (t2[i]) begin
      do_req(0, t2[i].addr, 0, h, rd, lat);
      check($sformatf("t2_hit_%0d", i),  h,  t2[i].hit);
      check($sformatf("t2_data_%0d", i), rd, t2[i].data);
    end
    check("t2_miss_cnt", miss_cnt, 4);
    check("t2_hit_cnt",  hit_cnt,  3);
    check("t2_no_wb",    wb_cnt,   0);

    // Test 3: write-allocate without fetch, then read hit
    do_reset();
    fc = fill_cnt; wc = wb_cnt;
    do_req(1, 32'h200, 32'hDEAD_BEEF, h, rd, lat);
    check("t3_wr_hit",    h, 0);
    check("t3_wr_nofill", fill_cnt, fc);
    check("t3_wr_nowb",   wb_cnt, wc);
    do_req(0, 32'h200, 0, h, rd, lat);
    check("t3_rd_hit",  h,  1);
    check("t3_rd_data", rd, 32'hDEAD_BEEF);

    // Test 4: clean fill into the other way, then dirty eviction
    do_req(0, 32'h300, 0, h, rd, lat);
    check("t4_300_hit",  h,  0);
    check("t4_300_data", rd, 32'hA5A5_0300);
    check("t4_300_nowb", wb_cnt, wc);
    do_req(0, 32'h400, 0, h, rd, lat);
    check("t4_wb_cnt",    wb_cnt, wc + 1);
    check("t4_wb_addr",   last_wb_addr, 32'h200);
    check("t4_wb_data",   last_wb_data, 32'hDEAD_BEEF);
    check("t4_fill_addr", last_fill_addr, 32'h400);
    check("t4_wb_first",  wb_seq < fill_seq, 1);
    check("t4_hit",       h,  0);
    check("t4_data",      rd, 32'hA5A5_0400);

    // Test 5: slow fill, ignored request pulses, single response
    ack_dly = 5;
    mc = miss_cnt; hc = hit_cnt;
    req_valid = 1; req_write = 0; req_addr = 32'h500; req_wdata = 0;
    @(posedge clk); #1;
    nreq = 0; nresp = 0; stable_ok = 1; ready_bad = 0; got_hit = 1; got_rd = 0;
    for (int c = 0; c < 20; c++) begin
      if (mem_req) begin
        nreq++;
        if (mem_addr != 32'h500 || mem_we) stable_ok = 0;
      end
      if (resp_valid) begin
        nresp++; got_hit = resp_hit; got_rd = resp_rdata;
      end
      if (req_ready && nresp == 0) ready_bad = 1;
      req_valid = (nresp == 0) ? c[0] : 1'b0;
      req_addr  = 32'h40;
      @(posedge clk); #1;
    end
    check("t5_req_cycles", nreq, 6);
    check("t5_stable",     stable_ok, 1);
    check("t5_ready_low",  ready_bad, 0);
    check("t5_one_resp",   nresp, 1);
    check("t5_resp_hit",   got_hit, 0);
    check("t5_resp_data",  got_rd, 32'hA5A5_0500);
    check("t5_miss_cnt",   miss_cnt, mc + 1);
    check("t5_hit_cnt",    hit_cnt, hc);

    // Test 6: reset during a fill
    req_valid = 1; req_write = 0; req_addr = 32'h600;
    @(posedge clk); #1;
    req_valid = 0;
    @(posedge clk); #1;
    check("t6_in_fill", mem_req, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_mem_req",  mem_req,  0);
    check("t6_rst_hit_cnt",  hit_cnt,  0);
    check("t6_rst_miss_cnt", miss_cnt, 0);
    check("t6_rst_ready",    req_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ack_dly = 1;
    do_req(0, 32'h0, 0, h, rd, lat);
    check("t6_miss_hit",  h,  0);
    check("t6_miss_data", rd, 32'h1111_0000);
    check("t6_miss_cnt",  miss_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_sa_wb.md
Name: cache_sa_wb

Overview:
Parametrised N-way set-associative, write-back, write-allocate cache; successor to the single-way `cache` block.
- Adds true-LRU replacement, dirty-line writeback and a ready/valid CPU interface.
- Adds a req/ack backing-memory port and saturating hit/miss counters.
- Sits between a CPU-side requester and a slow memory model or controller; one word per line.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, word/line width (power of 2, ≥8)
NUM_SETS, 4, number of sets (power of 2, ≥2)
WAYS, 2, associativity (power of 2, ≥2)
CNT_W, 16, width of hit/miss statistics counters

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  CPU request valid
req_ready  out  1  cache can accept; high only in IDLE
req_write  in  1  1=write, 0=read
req_addr  in  ADDR_W  byte address (low log2(DATA_W/8) bits ignored)
req_wdata  in  DATA_W  write data
resp_valid  out  1  one-cycle response pulse
resp_hit  out  1  request hit (qualified by resp_valid)
resp_rdata  out  DATA_W  read data (qualified by resp_valid && !req_write of the request)
mem_req  out  1  memory transaction request, held until mem_ack
mem_we  out  1  1=writeback, 0=fill
mem_addr  out  ADDR_W  word-aligned memory address
mem_wdata  out  DATA_W  writeback data
mem_ack  in  1  memory completes transaction this cycle; mem_rdata valid when !mem_we
mem_rdata  in  DATA_W  fill data
hit_cnt  out  CNT_W  saturating hit count
miss_cnt  out  CNT_W  saturating miss count

Behaviour:
- Address split: OFF=log2(DATA_W/8) low bits; index=next log2(NUM_SETS) bits; tag=remaining upper bits.
- Reset (async assert, sync-released use):
  - state=IDLE; all valid=0, dirty=0; age[set][w]=w.
  - Outputs low: req_ready=1, resp_valid=0, resp_hit=0, resp_rdata=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, counters=0.
- Request is accepted on the clock edge with req_valid && req_ready. Request fields are registered; the requester may change them afterwards.
- FSM: IDLE, WB, FILL, RESP.
- IDLE, hit:
  - read returns the way's data; write updates the data and sets dirty.
  - LRU is updated; resp_valid=1, resp_hit=1 the next cycle. Hit latency = 1 cycle; state stays IDLE, back-to-back hits at full rate.
- IDLE, miss: the victim is the lowest-index invalid way, else the way with maximum age.
  - Victim valid && dirty -> WB.
  - Else read -> FILL; write -> RESP, installing req_wdata with dirty=1 and no fetch.
- WB: mem_req=1, mem_we=1, mem_addr={victim tag,index,0}, mem_wdata=victim data, all stable until mem_ack. On mem_ack: read -> FILL; write -> RESP (install as above).
- FILL: mem_req=1, mem_we=0, mem_addr=aligned req address. On mem_ack: install mem_rdata, valid=1, dirty=0, -> RESP.
- RESP: resp_valid=1, resp_hit=0; resp_rdata = filled data (reads); -> IDLE. req_ready is low in WB/FILL/RESP.
- LRU on each hit or install to way w:
  - every way with age < age[w] increments; age[w]=0.
  - Ages stay a permutation of 0..WAYS-1.
- hit_cnt/miss_cnt increment once per accepted request and saturate at all-ones.
- mem_ack outside WB/FILL is ignored. req_valid while req_ready=0 is ignored; the requester holds.
- Reset mid-transaction: immediate return to reset state; mem_req drops in the same cycle; dirty data is lost by design.

Decomposition:
- Package cache_pkg: state enum (IDLE, WB, FILL, RESP) and a $clog2-based field-width helper for OFF/IDX/TAG.
- Sub-module cache_lru: holds per-set age vectors, exposes victim selection (given the valid mask) and the touch-update. Parametrised by NUM_SETS and WAYS.

Test Plan (defaults; memory acks after 1 cycle unless stated):
1. Read 0x0 with mem_rdata=0x1111_0000 -> FILL at mem_addr 0x0, resp hit=0 data 0x1111_0000. Read 0x0 again -> resp one cycle after accept, hit=1 data 0x1111_0000, no mem_req.
2. Read 0x40 (miss), 0x40 (hit), 0x0 (hit: two ways hold both), 0x80 (miss, evicts 0x40 as LRU), 0x40 -> miss. miss_cnt=4, hit_cnt=3 including test 1.
3. After reset, write 0x200 data 0xDEAD_BEEF -> hit=0, no mem_req. Read 0x200 -> hit=1, data 0xDEAD_BEEF.
4. Continue from 3: read 0x300 (miss, clean fill), then read 0x400 -> WB mem_we=1 mem_addr 0x200 mem_wdata 0xDEAD_BEEF, then FILL mem_addr 0x400, resp hit=0.
5. mem_ack delayed 5 cycles on a fill -> mem_req/mem_addr stable throughout, req_ready=0, req_valid pulses ignored, single resp_valid.
6. rst_n low during FILL -> mem_req=0 immediately, counters 0. After release, read 0x0 -> miss.
